// File: rtl/irq_if.sv
// CPU/peripheral-facing signal bundle of the interrupt controller.
// The slave modport is the controller's view; the master modport drives the events and the CPU handshake.
interface irq_if #(
    parameter int NSRC = 4,
    parameter int VECW = 2,
    parameter int PCW  = 10
);
    logic [NSRC-1:0] pulse_in;
    logic            mask_we;
    logic [NSRC-1:0] mask_din;
    logic            ack;
    logic            eoi;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pending;
    logic            irq;
    logic [VECW-1:0] irq_id;
    logic [PCW-1:0]  irq_addr;

    modport master (
        output pulse_in, mask_we, mask_din, ack, eoi,
        input  mask, pending, irq, irq_id, irq_addr
    );

    modport slave (
        input  pulse_in, mask_we, mask_din, ack, eoi,
        output mask, pending, irq, irq_id, irq_addr
    );
endinterface

// File: rtl/irq_ctrl.sv
// Latches event pulses into pending flags, masks them and raises one fixed-priority
// interrupt request (index 0 highest) with an ISR vector; ack takes it, eoi ends the ISR.
module irq_ctrl #(
    parameter int              NSRC     = 4,
    parameter int              VECW     = 2,
    parameter int              PCW      = 10,
    parameter logic [PCW-1:0]  VEC_BASE = 10'h3F0
) (
    input  logic clk,
    input  logic reset,
    irq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] mask_q;
    logic            irq_q;
    logic [VECW-1:0] id_q;

    logic [NSRC-1:0] active;
    logic [NSRC-1:0] ack_clr;
    logic [VECW-1:0] win_id;

    // Scanning from the top down leaves the lowest active index as the winner.
    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path can hold an old value and infer a latch.
    always_comb begin
        active = pending_q & mask_q;
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) win_id = VECW'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        if (state == REQ && bus.ack) ack_clr[id_q] = 1'b1;
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            id_q      <= '0;
        end else begin
            if (bus.mask_we) mask_q <= bus.mask_din;
            // A pulse arriving on the acknowledged source keeps it pending.
            pending_q <= (pending_q & ~ack_clr) | bus.pulse_in;

            case (state)
                IDLE: begin
                    if (|active) begin
                        state <= REQ;
                        irq_q <= 1'b1;
                        id_q  <= win_id;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        state <= SERVICE;
                        irq_q <= 1'b0;
                    end else if (!mask_q[id_q]) begin
                        state <= IDLE;
                        irq_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mask     = mask_q;
    assign bus.pending  = pending_q;
    assign bus.irq      = irq_q;
    assign bus.irq_id   = id_q;
    assign bus.irq_addr = VEC_BASE + PCW'({id_q, 2'b00});
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table for the basic request/ack/eoi flow,
// then hand-written sequences for masking, re-pulse during ack, vector wrap and reset abort.
module tb_irq_ctrl;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    irq_if #(.NSRC(4), .VECW(2), .PCW(10)) i0 ();
    irq_if #(.NSRC(4), .VECW(2), .PCW(10)) i5 ();

    irq_ctrl #(.NSRC(4), .VECW(2), .PCW(10), .VEC_BASE(10'h3F0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (i0.slave)
    );

    irq_ctrl #(.NSRC(4), .VECW(2), .PCW(10), .VEC_BASE(10'h3FC)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (i5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] pulse;
        logic       mwe;
        logic [3:0] mdin;
        logic       ack;
        logic       eoi;
        logic       chk_req;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
        logic       e_irq;
        logic [1:0] e_id;
        logic [9:0] e_addr;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset       = 1'b1;
        i0.pulse_in = '0;
        i0.mask_we  = 1'b0;
        i0.mask_din = '0;
        i0.ack      = 1'b0;
        i0.eoi      = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic e_irq, input logic [1:0] e_id,
                             input logic [9:0] e_addr);
        check({tag, ".irq"},      32'(i0.irq),      32'(e_irq));
        check({tag, ".irq_id"},   32'(i0.irq_id),   32'(e_id));
        check({tag, ".irq_addr"}, 32'(i0.irq_addr), 32'(e_addr));
    endtask

    initial begin
        idle_inputs();
        reset       = 1'b0;
        i5.pulse_in = '0;
        i5.mask_we  = 1'b0;
        i5.mask_din = '0;
        i5.ack      = 1'b0;
        i5.eoi      = 1'b0;

        //         rst   pulse mwe   mdin  ack   eoi   chk   pend  mask  irq   id    addr
        vecs[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 10'h3F0};
        vecs[1]  = '{1'b1, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 10'h3F0};
        vecs[2]  = '{1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 2'd0, 10'h3F0};
        vecs[3]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 10'h3F0};
        vecs[4]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 10'h3F0};
        vecs[5]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 10'h3F0};
        vecs[6]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 10'h3F0};
        vecs[7]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 10'h3F0};
        vecs[8]  = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 4'hF, 1'b0, 2'd0, 10'h3F0};
        vecs[9]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 4'hF, 1'b1, 2'd1, 10'h3F4};
        vecs[10] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 4'hF, 1'b1, 2'd1, 10'h3F4};
        vecs[11] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h8, 4'hF, 1'b0, 2'd1, 10'h3F4};
        vecs[12] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h8, 4'hF, 1'b0, 2'd1, 10'h3F4};
        vecs[13] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h8, 4'hF, 1'b0, 2'd0, 10'h000};
        vecs[14] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h8, 4'hF, 1'b1, 2'd3, 10'h3FC};
        vecs[15] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd3, 10'h3FC};
        vecs[16] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 2'd3, 10'h3FC};

        // Basic flow: single source, then two sources serviced in priority order.
        for (int v = 0; v < 17; v++) begin
            reset       = vecs[v].rst;
            i0.pulse_in = vecs[v].pulse;
            i0.mask_we  = vecs[v].mwe;
            i0.mask_din = vecs[v].mdin;
            i0.ack      = vecs[v].ack;
            i0.eoi      = vecs[v].eoi;
            tick();
            check($sformatf("vec%0d.pending", v), 32'(i0.pending), 32'(vecs[v].e_pend));
            check($sformatf("vec%0d.mask", v),    32'(i0.mask),    32'(vecs[v].e_mask));
            if (vecs[v].chk_req)
                check_req($sformatf("vec%0d", v), vecs[v].e_irq, vecs[v].e_id, vecs[v].e_addr);
            if (v == 0) begin
                check("vec0.dut5_addr", 32'(i5.irq_addr), 32'h3FC);
                check("vec0.dut5_irq",  32'(i5.irq),      32'h0);
            end
        end
        idle_inputs();
        tick();
        check_req("idle_after_vecs", 1'b0, 2'd3, 10'h3FC);

        // Masked source stays pending, unmasking raises it, masking before ack withdraws it.
        i0.mask_we = 1'b1; i0.mask_din = 4'h0; tick();
        i0.mask_we = 1'b0; i0.pulse_in = 4'h4; tick();
        i0.pulse_in = 4'h0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("masked%0d.irq", c), 32'(i0.irq), 32'h0);
        end
        check("masked.pending", 32'(i0.pending), 32'h4);
        i0.mask_we = 1'b1; i0.mask_din = 4'h4; tick();
        i0.mask_we = 1'b0;
        check("unmask.irq_same_edge", 32'(i0.irq), 32'h0);
        tick();
        tick();
        check_req("unmask", 1'b1, 2'd2, 10'h3F8);
        i0.mask_we = 1'b1; i0.mask_din = 4'h0; tick();
        i0.mask_we = 1'b0;
        tick();
        tick();
        check("remask.irq", 32'(i0.irq), 32'h0);
        check("remask.pending", 32'(i0.pending), 32'h4);
        tick();
        check("remask.irq_stays", 32'(i0.irq), 32'h0);

        // Re-pulse on the acknowledged source keeps it pending; continuous pulses never lock up.
        reset = 1'b0; tick(); reset = 1'b1;
        i0.mask_we = 1'b1; i0.mask_din = 4'h1; tick();
        i0.mask_we = 1'b0; i0.pulse_in = 4'h1; tick();
        i0.pulse_in = 4'h0; tick();
        check_req("repulse.req", 1'b1, 2'd0, 10'h3F0);
        i0.ack = 1'b1; i0.pulse_in = 4'h1; tick();
        i0.ack = 1'b0; i0.pulse_in = 4'h0;
        check("repulse.irq_after_ack", 32'(i0.irq), 32'h0);
        check("repulse.pending", 32'(i0.pending), 32'h1);
        i0.eoi = 1'b1; tick(); i0.eoi = 1'b0;
        tick();
        tick();
        check_req("repulse.rearm", 1'b1, 2'd0, 10'h3F0);
        i0.pulse_in = 4'h1;
        for (int r = 0; r < 3; r++) begin
            i0.ack = 1'b1; tick(); i0.ack = 1'b0;
            check($sformatf("cont%0d.irq_low", r), 32'(i0.irq), 32'h0);
            check($sformatf("cont%0d.pending", r), 32'(i0.pending), 32'h1);
            i0.eoi = 1'b1; tick(); i0.eoi = 1'b0;
            tick();
            tick();
            check_req($sformatf("cont%0d.rearm", r), 1'b1, 2'd0, 10'h3F0);
        end
        i0.pulse_in = 4'h0;
        i0.ack = 1'b1; tick(); i0.ack = 1'b0;
        check("cont.drain_pending", 32'(i0.pending), 32'h0);
        i0.eoi = 1'b1; tick(); i0.eoi = 1'b0;
        tick();
        tick();
        check("cont.drain_irq", 32'(i0.irq), 32'h0);

        // Vector address wraps past the top of the PC space.
        i5.mask_we = 1'b1; i5.mask_din = 4'h2; tick();
        i5.mask_we = 1'b0; i5.pulse_in = 4'h2; tick();
        i5.pulse_in = 4'h0; tick();
        check("wrap.irq",      32'(i5.irq),      32'h1);
        check("wrap.irq_id",   32'(i5.irq_id),   32'h1);
        check("wrap.irq_addr", 32'(i5.irq_addr), 32'h000);

        // Reset during SERVICE aborts everything; the block then behaves as freshly reset.
        reset = 1'b0; tick(); reset = 1'b1;
        i0.mask_we = 1'b1; i0.mask_din = 4'hF; tick();
        i0.mask_we = 1'b0; i0.pulse_in = 4'h1; tick();
        i0.pulse_in = 4'h0; tick();
        i0.ack = 1'b1; i0.pulse_in = 4'h2; tick();
        i0.ack = 1'b0; i0.pulse_in = 4'h0;
        check("abort.pre_pending", 32'(i0.pending), 32'h2);
        check("abort.pre_irq", 32'(i0.irq), 32'h0);
        reset = 1'b0; tick(); reset = 1'b1;
        check("abort.pending", 32'(i0.pending), 32'h0);
        check("abort.mask", 32'(i0.mask), 32'h0);
        check_req("abort", 1'b0, 2'd0, 10'h3F0);
        i0.eoi = 1'b1; tick(); i0.eoi = 1'b0;
        tick();
        check("abort.eoi_ignored_irq", 32'(i0.irq), 32'h0);
        check("abort.eoi_ignored_pending", 32'(i0.pending), 32'h0);
        reset = 1'b0; tick(); reset = 1'b1;
        i0.mask_we = 1'b1; i0.mask_din = 4'hF; tick();
        i0.mask_we = 1'b0; i0.ack = 1'b1; i0.pulse_in = 4'h2; tick();
        i0.ack = 1'b0; i0.pulse_in = 4'h0;
        reset = 1'b0; tick(); reset = 1'b1;
        i0.mask_we = 1'b1; i0.mask_din = 4'hF; i0.pulse_in = 4'h4; tick();
        i0.mask_we = 1'b0; i0.pulse_in = 4'h0; tick();
        tick();
        check_req("abort.fresh_idle", 1'b1, 2'd2, 10'h3F8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
